eth_tx_frame_fifo: RTL

ETH_TX_FRAME_FIFO -- requirements
Module: eth_tx_frame_fifo

---
 rtl/eth_pkg.sv | 17 +
 rtl/eth_sdp_ram.sv | 28 ++
 rtl/eth_tx_frame_fifo.sv | 135 +++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet frame constants and TX FIFO write-FSM state type
package eth_pkg;

  localparam int ETH_MIN_LEN = 60;
  localparam int ETH_MAX_LEN = 1514;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_ACTIVE = 2'd1,
    W_DROP   = 2'd2
  } wr_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth_sdp_ram.sv
// rtl/eth_sdp_ram.sv - simple dual-port RAM, one write port, one registered read port
module eth_sdp_ram #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2048
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register doubles as the stream output register, so it is cleared on reset.
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/eth_tx_frame_fifo.sv
// rtl/eth_tx_frame_fifo.sv - store-and-forward TX frame FIFO; drops aborted, oversize
// and overflowing frames without ever back-pressuring the producer.
module eth_tx_frame_fifo
  import eth_pkg::*;
#(
  parameter int DEPTH   = 2048,
  parameter int MAX_LEN = ETH_MAX_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [11:0] frame_count,
  output logic [15:0] drop_count
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  ptr_t        wr_ptr, wr_commit, rd_ptr, rd_addr;
  wr_state_t   state, state_next;
  logic [15:0] length, len_next;
  logic        beat, full, too_long;
  logic        do_write, do_drop, do_commit;
  logic        out_valid, out_take, fetch;
  logic [8:0]  rd_data;

  assign s_axis_tready = ~rst;
  assign beat          = s_axis_tvalid & s_axis_tready;
  // rd_ptr trails the output register, so a byte waiting there still occupies its slot.
  assign full          = (ptr_t'(wr_ptr - rd_ptr) == ptr_t'(DEPTH));
  assign len_next      = (state == W_ACTIVE) ? length + 16'd1 : 16'd1;
  assign too_long      = (len_next > 16'(MAX_LEN));

  always_ff @(posedge clk) begin
    if (rst) state <= W_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    do_write   = 1'b0;
    do_drop    = 1'b0;
    do_commit  = 1'b0;
    case (state)
      W_IDLE, W_ACTIVE: begin
        if (beat) begin
          if (full || too_long || (s_axis_tlast && s_axis_tuser)) begin
            do_drop    = 1'b1;
            state_next = s_axis_tlast ? W_IDLE : W_DROP;
          end else begin
            do_write = 1'b1;
            if (s_axis_tlast) begin
              do_commit  = 1'b1;
              state_next = W_IDLE;
            end else begin
              state_next = W_ACTIVE;
            end
          end
        end
      end
      W_DROP: begin
        if (beat && s_axis_tlast) state_next = W_IDLE;
      end
      default: state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      wr_commit  <= '0;
      length     <= '0;
      drop_count <= '0;
    end else if (do_drop) begin
      wr_ptr     <= wr_commit;
      drop_count <= sat_inc16(drop_count);
    end else if (do_write) begin
      wr_ptr <= wr_ptr + ptr_t'(1);
      length <= len_next;
      if (do_commit) wr_commit <= wr_ptr + ptr_t'(1);
    end
  end

  // Prefetch whenever the output register is empty or draining this cycle.
  assign out_take = out_valid & m_axis_tready;
  assign fetch    = (rd_addr != wr_commit) && (!out_valid || m_axis_tready);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr     <= '0;
      rd_ptr      <= '0;
      out_valid   <= 1'b0;
      frame_count <= '0;
    end else begin
      if (fetch)         rd_addr   <= rd_addr + ptr_t'(1);
      if (fetch)         out_valid <= 1'b1;
      else if (out_take) out_valid <= 1'b0;
      if (out_take)      rd_ptr    <= rd_ptr + ptr_t'(1);
      case ({do_commit, out_take & rd_data[8]})
        2'b10:   frame_count <= frame_count + 12'd1;
        2'b01:   frame_count <= frame_count - 12'd1;
        default: frame_count <= frame_count;
      endcase
    end
  end

  eth_sdp_ram #(
    .WIDTH(9),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (do_write),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data ({s_axis_tlast, s_axis_tdata}),
    .rd_en   (fetch),
    .rd_addr (rd_addr[AW-1:0]),
    .rd_data (rd_data)
  );

  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = rd_data[7:0];
  assign m_axis_tlast  = rd_data[8] & out_valid;
  assign m_axis_tuser  = 1'b0;

endmodule
